// File: rtl/dma_defs.sv
// Shared encodings for the DMA address generator:
// transfer modes, FSM states and mode helpers.
package dma_defs;

  typedef enum logic [1:0] {
    MODE_STOP   = 2'b00,
    MODE_CMP    = 2'b01,
    MODE_REINIT = 2'b10,
    MODE_FREE   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic wc_counts_up(mode_e m);
    return m == MODE_CMP;
  endfunction

  // Free-run never terminates, so a zero base cannot end it early
  function automatic logic mode_terminates(mode_e m);
    return m != MODE_FREE;
  endfunction

endpackage

// File: rtl/updown_counter_p.sv
// Loadable up/down counter with a wrap flag that
// marks an enabled step across the all-ones/zero edge.
module updown_counter_p #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (up) begin
        cnt_d = cnt_q + 1'b1;
        wrap  = &cnt_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
        wrap  = ~|cnt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/dma_addr_gen.sv
// DMA address generator: address and word counters
// sequenced by an IDLE/RUN/DONE transfer FSM.
module dma_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int WC_W   = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              load_addr,
  input  logic              load_wc,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [WC_W-1:0]   wc_in,
  input  logic [1:0]        mode,
  input  logic              up,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] addr_out,
  output logic [WC_W-1:0]   wc_out,
  output logic              busy,
  output logic              done,
  output logic              carry_out
);

  import dma_defs::*;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  mode_e             mode_in;
  logic [ADDR_W-1:0] abase_q, abase_d;
  logic [WC_W-1:0]   wbase_q, wbase_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              carry_q, carry_d;

  logic [ADDR_W-1:0] addr_q;
  logic [WC_W-1:0]   wc_q;
  logic [WC_W-1:0]   wc_inc;
  logic              addr_wrap;
  logic              wc_wrap;

  logic              any_load;
  logic              in_run;
  logic              start_ok;
  logic              do_step;
  logic              wc_one;
  logic              stop_term;
  logic              reinit_term;
  logic              zero_start;
  logic              addr_ld;
  logic              wc_ld;
  logic [WC_W-1:0]   wc_ld_val;

  assign mode_in = mode_e'(mode);
  assign wc_inc  = wc_q + 1'b1;

  always_comb begin
    any_load = load_addr | load_wc;
    in_run   = state_q == ST_RUN;
    start_ok = start & ~in_run;
    // Any load in the same cycle takes precedence over a step
    do_step  = in_run & step & ~any_load;
    abase_d  = load_addr ? addr_in : abase_q;
    wbase_d  = load_wc ? wc_in : wbase_q;
    mode_d   = start_ok ? mode_in : mode_q;
    wc_one   = wc_q == WC_W'(1);
    stop_term = do_step &
      (((mode_q == MODE_STOP) & wc_one) |
       ((mode_q == MODE_CMP) & (wc_inc == wbase_q)));
    reinit_term = do_step & (mode_q == MODE_REINIT) & wc_one;
    zero_start  = start_ok & (wbase_d == '0) &
                  mode_terminates(mode_in);
  end

  always_comb begin
    addr_ld   = load_addr | start_ok | reinit_term;
    wc_ld     = start_ok | reinit_term;
    wc_ld_val = wbase_d;
    if (start_ok & wc_counts_up(mode_in)) wc_ld_val = '0;
  end

  updown_counter_p #(
    .W (ADDR_W)
  ) u_addr_cnt (
    .clk      (clk),
    .res      (res),
    .load     (addr_ld),
    .load_val (abase_d),
    .en       (do_step),
    .up       (up),
    .q        (addr_q),
    .wrap     (addr_wrap)
  );

  updown_counter_p #(
    .W (WC_W)
  ) u_wc_cnt (
    .clk      (clk),
    .res      (res),
    .load     (wc_ld),
    .load_val (wc_ld_val),
    .en       (do_step),
    .up       (wc_counts_up(mode_q)),
    .q        (wc_q),
    .wrap     (wc_wrap)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_STOP;
      abase_q <= '0;
      wbase_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      abase_q <= abase_d;
      wbase_q <= wbase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = zero_start ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (stop_term) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start)         state_d = zero_start ? ST_DONE : ST_RUN;
        else if (any_load) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d  = state_d == ST_RUN;
    done_d  = (state_d == ST_DONE) | reinit_term;
    // Reload replaces the step, so wrap is already masked
    carry_d = addr_wrap;
  end

  assign addr_out  = addr_q;
  assign wc_out    = wc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign carry_out = carry_q;

  logic unused_wc_wrap;
  assign unused_wc_wrap = wc_wrap;

endmodule

// File: tb/tb_dma_addr_gen.sv
// Self-checking bench for dma_addr_gen: directed cases
// plus randomized traffic against a behavioural model.
module tb_dma_addr_gen;

  localparam int ADDR_W = 8;
  localparam int WC_W   = 8;
  localparam int AMOD   = 1 << ADDR_W;
  localparam int WMOD   = 1 << WC_W;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic              clk = 1'b0;
  logic              res;
  logic              load_addr;
  logic              load_wc;
  logic [ADDR_W-1:0] addr_in;
  logic [WC_W-1:0]   wc_in;
  logic [1:0]        mode;
  logic              up;
  logic              start;
  logic              step;
  logic [ADDR_W-1:0] addr_out;
  logic [WC_W-1:0]   wc_out;
  logic              busy;
  logic              done;
  logic              carry_out;

  dma_addr_gen #(
    .ADDR_W (ADDR_W),
    .WC_W   (WC_W)
  ) dut (
    .clk       (clk),
    .res       (res),
    .load_addr (load_addr),
    .load_wc   (load_wc),
    .addr_in   (addr_in),
    .wc_in     (wc_in),
    .mode      (mode),
    .up        (up),
    .start     (start),
    .step      (step),
    .addr_out  (addr_out),
    .wc_out    (wc_out),
    .busy      (busy),
    .done      (done),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  int m_st, m_mode, m_addr, m_wc, m_ab, m_wb;
  bit m_busy, m_done, m_carry;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t",
                  name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_st = S_IDLE;
    m_mode = 0;
    m_addr = 0;
    m_wc = 0;
    m_ab = 0;
    m_wb = 0;
    m_busy = 0;
    m_done = 0;
    m_carry = 0;
  endtask

  task automatic model_update();
    int nab, nwb;
    bit ld, pulse;
    if (res) begin
      model_reset();
      return;
    end
    ld = load_addr || load_wc;
    nab = load_addr ? int'(addr_in) : m_ab;
    nwb = load_wc ? int'(wc_in) : m_wb;
    pulse = 0;
    m_carry = 0;
    if (load_addr) m_addr = nab;
    if (m_st != S_RUN && start) begin
      m_mode = int'(mode);
      m_addr = nab;
      m_wc = (m_mode == 1) ? 0 : nwb;
      m_st = (nwb == 0 && m_mode != 3) ? S_DONE : S_RUN;
    end else if (m_st == S_RUN && step && !ld) begin
      if (up) begin
        m_carry = (m_addr == AMOD - 1);
        m_addr = (m_addr + 1) % AMOD;
      end else begin
        m_carry = (m_addr == 0);
        m_addr = (m_addr + AMOD - 1) % AMOD;
      end
      if (m_mode == 1) begin
        m_wc = (m_wc + 1) % WMOD;
        if (m_wc == m_wb) m_st = S_DONE;
      end else begin
        m_wc = (m_wc + WMOD - 1) % WMOD;
        if (m_wc == 0 && m_mode == 0) m_st = S_DONE;
        if (m_wc == 0 && m_mode == 2) begin
          m_addr = m_ab;
          m_wc = m_wb;
          m_carry = 0;
          pulse = 1;
        end
      end
    end else if (m_st == S_DONE && ld) begin
      m_st = S_IDLE;
    end
    m_ab = nab;
    m_wb = nwb;
    m_busy = (m_st == S_RUN);
    m_done = (m_st == S_DONE) || pulse;
  endtask

  task automatic check_model();
    chk("addr_out", 32'(addr_out), 32'(m_addr));
    chk("wc_out", 32'(wc_out), 32'(m_wc));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("carry_out", 32'(carry_out), 32'(m_carry));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_model();
    @(negedge clk);
    load_addr = 0;
    load_wc = 0;
    start = 0;
    step = 0;
  endtask

  logic [7:0] exp_a [5];
  logic       exp_d [5];
  logic [7:0] exp_w [5];
  logic [7:0] edges [4];

  initial begin
    res = 1;
    load_addr = 0;
    load_wc = 0;
    addr_in = '0;
    wc_in = '0;
    mode = 2'b00;
    up = 1;
    start = 0;
    step = 0;
    model_reset();
    #2;
    chk("rst addr", 32'(addr_out), 32'h0);
    chk("rst wc", 32'(wc_out), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    chk("rst carry", 32'(carry_out), 32'h0);
    @(negedge clk);
    res = 0;

    // Count-down stop across the address wrap
    load_addr = 1; addr_in = 8'hFE;
    load_wc = 1; wc_in = 8'd3;
    tick();
    chk("r35 load addr", 32'(addr_out), 32'hFE);
    mode = 2'b00; up = 1; start = 1;
    tick();
    chk("r35 start busy", 32'(busy), 32'h1);
    chk("r35 start wc", 32'(wc_out), 32'h3);
    step = 1; tick();
    chk("r35 s1 addr", 32'(addr_out), 32'hFF);
    chk("r35 s1 carry", 32'(carry_out), 32'h0);
    step = 1; tick();
    chk("r35 s2 addr", 32'(addr_out), 32'h00);
    chk("r35 s2 carry", 32'(carry_out), 32'h1);
    step = 1; tick();
    chk("r35 s3 addr", 32'(addr_out), 32'h01);
    chk("r35 s3 carry", 32'(carry_out), 32'h0);
    chk("r35 done", 32'(done), 32'h1);
    chk("r35 busy", 32'(busy), 32'h0);

    // Compare stop, counting the address down
    load_addr = 1; addr_in = 8'h10;
    load_wc = 1; wc_in = 8'd4;
    tick();
    chk("r36 done clr", 32'(done), 32'h0);
    mode = 2'b01; up = 0; start = 1;
    tick();
    chk("r36 start wc", 32'(wc_out), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step = 1;
      tick();
    end
    chk("r36 addr", 32'(addr_out), 32'h0C);
    chk("r36 wc", 32'(wc_out), 32'h4);
    chk("r36 done", 32'(done), 32'h1);
    chk("r36 busy", 32'(busy), 32'h0);

    // Auto-reinit keeps running and pulses done
    load_addr = 1; addr_in = 8'h20;
    load_wc = 1; wc_in = 8'd2;
    tick();
    mode = 2'b10; up = 1; start = 1;
    tick();
    exp_a = '{8'h21, 8'h20, 8'h21, 8'h20, 8'h21};
    exp_d = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_w = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1};
    for (int i = 0; i < 5; i++) begin
      step = 1;
      tick();
      chk("r37 addr", 32'(addr_out), 32'(exp_a[i]));
      chk("r37 done", 32'(done), 32'(exp_d[i]));
      chk("r37 wc", 32'(wc_out), 32'(exp_w[i]));
      chk("r37 busy", 32'(busy), 32'h1);
    end

    // Address load beats a step in RUN
    load_addr = 1; addr_in = 8'h80; step = 1;
    tick();
    chk("r40 addr", 32'(addr_out), 32'h80);
    chk("r40 wc", 32'(wc_out), 32'h1);
    chk("r40 busy", 32'(busy), 32'h1);

    #2 res = 1;
    #1;
    chk("abort addr", 32'(addr_out), 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    model_reset();
    tick();
    res = 0;

    // Zero word count terminates at once
    load_addr = 1; addr_in = 8'h55;
    tick();
    mode = 2'b00; up = 1; start = 1;
    tick();
    chk("r38 addr", 32'(addr_out), 32'h55);
    chk("r38 done", 32'(done), 32'h1);
    chk("r38 busy", 32'(busy), 32'h0);
    chk("r38 carry", 32'(carry_out), 32'h0);

    // Free-run, then asynchronous reset mid-cycle
    load_addr = 1; addr_in = 8'h30;
    load_wc = 1; wc_in = 8'd5;
    tick();
    mode = 2'b11; up = 1; start = 1;
    tick();
    step = 1; tick();
    step = 1; tick();
    chk("r39 pre addr", 32'(addr_out), 32'h32);
    chk("r39 pre wc", 32'(wc_out), 32'h3);
    chk("r39 pre busy", 32'(busy), 32'h1);
    #2 res = 1;
    #1;
    chk("r39 addr", 32'(addr_out), 32'h0);
    chk("r39 wc", 32'(wc_out), 32'h0);
    chk("r39 busy", 32'(busy), 32'h0);
    chk("r39 done", 32'(done), 32'h0);
    chk("r39 carry", 32'(carry_out), 32'h0);
    model_reset();
    tick();
    res = 0;

    // First transfer after reset release
    load_addr = 1; addr_in = 8'h0A;
    load_wc = 1; wc_in = 8'd1;
    tick();
    mode = 2'b00; up = 1; start = 1;
    tick();
    step = 1; tick();
    chk("r32 addr", 32'(addr_out), 32'h0B);
    chk("r32 done", 32'(done), 32'h1);

    edges = '{8'h00, 8'h01, 8'hFE, 8'hFF};
    for (int i = 0; i < 3000; i++) begin
      res = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 5) == 0);
      load_addr = !start && ($urandom_range(0, 15) == 0);
      load_wc = !start && ($urandom_range(0, 15) == 0);
      step = ($urandom_range(0, 3) != 0);
      up = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        addr_in = edges[$urandom_range(0, 3)];
      else
        addr_in = 8'($urandom);
      if ($urandom_range(0, 7) == 0)
        wc_in = 8'($urandom);
      else
        wc_in = 8'($urandom_range(0, 4));
      tick();
      res = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dma_addr_gen.md
DMA_ADDR_GEN -- requirements
Module: dma_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the address counter width (legal 4..32).
REQ-002 Parameter WC_W, default 8, SHALL set the word counter width (legal 4..32).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 res  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 load_addr  input  1  SHALL load addr_in into address base and address counter.
REQ-006 load_wc  input  1  SHALL load wc_in into word-count base register.
REQ-007 addr_in  input  ADDR_W  SHALL be the address load value.
REQ-008 wc_in  input  WC_W  SHALL be the word-count load value.
REQ-009 mode  input  2  SHALL select transfer mode; sampled only on start.
REQ-010 up  input  1  SHALL select address direction (1 increment, 0 decrement); sampled every step.
REQ-011 start  input  1  SHALL begin a transfer when in IDLE or DONE.
REQ-012 step  input  1  SHALL advance one word per cycle while in RUN.
REQ-013 addr_out  output  ADDR_W  SHALL be the current address counter.
REQ-014 wc_out  output  WC_W  SHALL be the current word counter.
REQ-015 busy  output  1  SHALL be high exactly while state is RUN.
REQ-016 done  output  1  SHALL indicate terminal count (see REQ-024..027).
REQ-017 carry_out  output  1  SHALL be a registered one-cycle pulse on address wrap.

Function
REQ-018 States SHALL be IDLE, RUN, DONE; start in IDLE/DONE -> RUN next cycle; start in RUN ignored.
REQ-019 On start, mode SHALL be latched; address counter SHALL reload from address base; word counter SHALL load wc base (modes 00,10,11) or 0 (mode 01).
REQ-020 start with wc base == 0 in modes 00/01/10 SHALL go to DONE next cycle with no address step.
REQ-021 Each RUN cycle with step=1 SHALL move address by +1 (up=1) or -1 (up=0) modulo 2^ADDR_W.
REQ-022 carry_out SHALL pulse the cycle after a step from all-ones to 0 (up) or 0 to all-ones (down); 0 otherwise.
REQ-023 load_addr/load_wc SHALL have priority over step in the same cycle; load_addr in RUN SHALL change address with no step applied that cycle.
REQ-024 Mode 00 (count-down stop): word counter decrements per step; step taking it 1 -> 0 SHALL enter DONE; done held high in DONE.
REQ-025 Mode 01 (compare stop): word counter increments per step; step making it equal wc base SHALL enter DONE; done held high.
REQ-026 Mode 10 (auto-reinit): as mode 00, but at terminal step SHALL reload address and word counter from bases, stay RUN, pulse done one cycle.
REQ-027 Mode 11 (free-run): word counter decrements with wrap; done SHALL never assert; only reset exits RUN.
REQ-028 DONE -> IDLE SHALL occur on load_addr or load_wc (done cleared); start in DONE -> RUN directly.
REQ-029 Counters SHALL hold value when step=0 or state != RUN (except loads/start reload).
REQ-030 Latency: address and word counter SHALL update one clock after step; done/busy registered, same edge as terminal counter update.

Reset
REQ-031 res=1 SHALL immediately force state IDLE, addr_out=0, wc_out=0, bases=0, latched mode=00, busy=0, done=0, carry_out=0.
REQ-032 Reset mid-transfer SHALL abort with no further steps; first start after release behaves as REQ-019.

Structure
REQ-033 Mode encodings (MODE_STOP, MODE_CMP, MODE_REINIT, MODE_FREE) and state encodings SHALL live in shared header dma_defs.
REQ-034 Address and word counters SHALL each instantiate sub-module updown_counter_p (parametrised width, load, enable, up, wrap pulse).

Verification
REQ-035 ADDR_W=8: load addr 0xFE, wc 3, mode 00, up=1, start, 3 steps -> addr 0xFF,0x00,0x01; carry_out pulse after 2nd step; done=1, busy=0.
REQ-036 Mode 01: wc base 4, addr 0x10, up=0, 4 steps -> addr 0x0C, wc_out 4, DONE.
REQ-037 Mode 10: addr 0x20, wc 2, 5 steps -> addr 0x21,0x20(reload),0x21,0x20,0x21; done pulses twice, busy stays 1.
REQ-038 Mode 00 wc base 0, start -> DONE next cycle, addr unchanged, no carry.
REQ-039 Mode 11, 2 steps then res=1 mid-cycle -> all outputs 0 asynchronously, state IDLE.
REQ-040 load_addr 0x80 with step=1 in RUN -> addr 0x80 next cycle, wc_out unchanged.
